row_flash_sequencer: RTL and testbench

ROW_FLASH_SEQUENCER -- requirements
Module: row_flash_sequencer

---
 rtl/row_flash_sequencer_pkg.sv | 40 ++++
 rtl/row_flash_sequencer_vsync_tick.sv | 38 +++
 rtl/row_flash_sequencer.sv | 154 +++++++++++++++
 tb/tb_row_flash_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_flash_sequencer_pkg.sv
// rtl/row_flash_sequencer_pkg.sv - shared types, geometry and cell mapping for the row flash sequencer
//
// Purpose: one place for the sequencer state encoding, the board geometry and
// the row/column to cell-bit mapping used by both the flash and matrix paths.
// Contents:
//   state_t      - sequencer states IDLE, ALIGN, FLASH, FIN
//   ROWS, COLS   - board geometry (20 rows of 10 cells)
//   CELLS        - total cell bits in a matrix or flash vector
//   cell_idx     - bit position of (row, col): row*COLS + col
//   expand_rows  - spread a per-row mask across every cell of those rows

package row_flash_sequencer_pkg;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    FLASH = 2'd2,
    FIN   = 2'd3
  } state_t;

  function automatic int cell_idx(input int row, input int col);
    return row * COLS + col;
  endfunction

  function automatic logic [CELLS-1:0] expand_rows(input logic [ROWS-1:0] rows);
    logic [CELLS-1:0] cells;
    cells = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cells[cell_idx(r, c)] = rows[r];
      end
    end
    return cells;
  endfunction

endpackage

// File: rtl/row_flash_sequencer_vsync_tick.sv
// rtl/row_flash_sequencer_vsync_tick.sv - vsync falling-edge detector producing a one-cycle frame tick
//
// Purpose: turn the active-low vertical sync pulse into a single-cycle frame
// tick. The tick is registered, so it is high in the cycle after the first
// low sample of vs that follows a high sample.
// Ports:
//   i_clk        in   pixel clock
//   i_rst        in   asynchronous active-high reset
//   i_vs         in   vertical sync, active low
//   o_frame_tick out  one-cycle frame tick

module vsync_tick
  import row_flash_sequencer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vs,
  output logic o_frame_tick
);

  logic r_vs_q;
  logic r_tick;

  // The sample register resets high so a vs that is already low when reset
  // releases still counts as a fresh falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vs_q <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_vs_q <= i_vs;
      r_tick <= r_vs_q & ~i_vs;
    end
  end

  assign o_frame_tick = r_tick;

endmodule

// File: rtl/row_flash_sequencer.sv
// rtl/row_flash_sequencer.sv - frame-aligned row flash sequencer for the row-clear display
//
// Purpose: on request, flash the selected rows of the displayed matrix for a
// fixed number of frame-aligned half-periods, keeping the displayed matrix
// frozen until the sequence ends.
// Ports:
//   clk        in   pixel clock
//   clr        in   asynchronous active-high reset
//   vs         in   vertical sync, active low
//   start      in   one-cycle flash request (taken only in IDLE)
//   row_mask   in   rows to flash, bit r = row r
//   matrix_in  in   live object matrix, bit r*COLS+c
//   matrix_out out  frame-latched matrix for the display
//   flash      out  per-cell flash enable, same mapping as matrix_in
//   busy       out  high from accepted start until the sequence finishes
//   done       out  one-cycle completion pulse

module row_flash_sequencer
  import row_flash_sequencer_pkg::*;
#(
  parameter int FRAMES_PER_TOGGLE = 8,
  parameter int FLASH_TOGGLES     = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             vs,
  input  logic             start,
  input  logic [ROWS-1:0]  row_mask,
  input  logic [CELLS-1:0] matrix_in,
  output logic [CELLS-1:0] matrix_out,
  output logic [CELLS-1:0] flash,
  output logic             busy,
  output logic             done
);

  localparam int FCW = $clog2(FRAMES_PER_TOGGLE + 1);
  localparam int TCW = $clog2(FLASH_TOGGLES + 1);

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_TOGGLE - 1);
  localparam logic [TCW-1:0] TOGGLE_END = TCW'(FLASH_TOGGLES);

  logic             w_frame_tick;
  logic [TCW-1:0]   w_toggle_next;

  state_t           r_state;
  logic [ROWS-1:0]  r_mask_q;
  logic             r_phase;
  logic [FCW-1:0]   r_frame_cnt;
  logic [TCW-1:0]   r_toggle_cnt;
  logic             r_busy;
  logic             r_done;
  logic [CELLS-1:0] r_flash;
  logic [CELLS-1:0] r_matrix_out;

  vsync_tick u_vsync_tick (
    .i_clk        (clk),
    .i_rst        (clr),
    .i_vs         (vs),
    .o_frame_tick (w_frame_tick)
  );

  assign w_toggle_next = r_toggle_cnt + TCW'(1);

  // Sequencer. flash is updated on exactly the edges where state or phase
  // change, so it always matches phase & mask & (state==FLASH) in the same
  // cycle instead of trailing it by one.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= IDLE;
      r_mask_q     <= '0;
      r_phase      <= 1'b0;
      r_frame_cnt  <= '0;
      r_toggle_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_flash      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (row_mask != '0) begin
              r_mask_q <= row_mask;
              r_busy   <= 1'b1;
              r_state  <= ALIGN;
            end else begin
              // Nothing to flash: report completion without ever going busy.
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end

        ALIGN: begin
          // A tick coincident with the accepting edge was seen in IDLE, so
          // the first tick handled here is strictly later.
          if (w_frame_tick) begin
            r_state      <= FLASH;
            r_phase      <= 1'b1;
            r_frame_cnt  <= '0;
            r_toggle_cnt <= '0;
            r_flash      <= expand_rows(r_mask_q);
          end
        end

        FLASH: begin
          if (w_frame_tick) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt  <= '0;
              r_toggle_cnt <= w_toggle_next;
              if (w_toggle_next == TOGGLE_END) begin
                r_phase <= 1'b0;
                r_flash <= '0;
                r_done  <= 1'b1;
                r_state <= FIN;
              end else begin
                r_phase <= ~r_phase;
                r_flash <= r_phase ? '0 : expand_rows(r_mask_q);
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + FCW'(1);
            end
          end
        end

        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Display matrix follows the live matrix once per frame while idle; it is
  // frozen for the whole sequence so cleared rows stay visible while flashing.
  // A start on the same cycle as the tick wins and suppresses the load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_matrix_out <= '0;
    end else if (r_state == IDLE && w_frame_tick && !start) begin
      r_matrix_out <= matrix_in;
    end
  end

  assign matrix_out = r_matrix_out;
  assign flash      = r_flash;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_row_flash_sequencer.sv
// tb/tb_row_flash_sequencer.sv - randomized self-checking bench for row_flash_sequencer

module tb_row_flash_sequencer;

  localparam int FPT = 2;
  localparam int FT  = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         vs = 1'b1;
  logic         start = 1'b0;
  logic [19:0]  row_mask = '0;
  logic [199:0] matrix_in = '0;
  logic [199:0] matrix_out;
  logic [199:0] flash;
  logic         busy;
  logic         done;

  always #20 clk = ~clk;

  row_flash_sequencer #(
    .FRAMES_PER_TOGGLE (FPT),
    .FLASH_TOGGLES     (FT)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .vs         (vs),
    .start      (start),
    .row_mask   (row_mask),
    .matrix_in  (matrix_in),
    .matrix_out (matrix_out),
    .flash      (flash),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int frame_pos = 0;
  int frame_len = 6;

  // Reference model: a sequence is idle, waiting for its first tick, running
  // (k ticks since the flash began), or reporting done for one cycle.
  typedef enum {M_IDLE, M_WAIT, M_RUN, M_DONE} mode_t;
  mode_t        m_mode;
  logic         m_busy;
  logic         m_tick;
  logic         m_vs_prev;
  int           m_k;
  logic [19:0]  m_mask;
  logic [199:0] m_matrix;
  logic [199:0] exp_flash;
  logic         exp_done;

  function automatic logic [199:0] row_cells(input logic [19:0] rows);
    logic [199:0] cells;
    logic [199:0] one_row;
    cells   = '0;
    one_row = 200'h3FF;
    for (int r = 0; r < 20; r++) begin
      if (rows[r]) cells = cells | (one_row << (r * 10));
    end
    return cells;
  endfunction

  function automatic logic [199:0] rand200();
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v = {v[167:0], $urandom()};
    return v;
  endfunction

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_busy    = 1'b0;
    m_tick    = 1'b0;
    m_vs_prev = 1'b1;
    m_k       = 0;
    m_mask    = '0;
    m_matrix  = '0;
    exp_flash = '0;
    exp_done  = 1'b0;
  endtask

  // One clock edge: update the model from the inputs seen at that edge, then
  // choose the next vs value (two low cycles per frame of random length).
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (clr) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            if (row_mask != '0) begin
              m_mode = M_WAIT;
              m_mask = row_mask;
              m_busy = 1'b1;
            end else begin
              m_mode = M_DONE;
            end
          end else if (m_tick) begin
            m_matrix = matrix_in;
          end
        end
        M_WAIT: if (m_tick) begin m_mode = M_RUN; m_k = 0; end
        M_RUN: begin
          if (m_tick) begin
            m_k++;
            if (m_k == FPT * FT) m_mode = M_DONE;
          end
        end
        M_DONE: begin m_mode = M_IDLE; m_busy = 1'b0; end
      endcase
      m_tick    = m_vs_prev & ~vs;
      m_vs_prev = vs;
    end
    exp_done  = (m_mode == M_DONE);
    exp_flash = (m_mode == M_RUN && ((m_k / FPT) % 2) == 0) ? row_cells(m_mask) : '0;
    if (done === 1'b1) n_done++;
    frame_pos++;
    if (frame_pos >= frame_len) begin
      frame_pos = 0;
      frame_len = $urandom_range(4, 9);
    end
    vs = (frame_pos < 2) ? 1'b0 : 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      advance();
      checks++; if (flash !== '0) begin errors++; $display("FAIL reset_flash got=%h exp=0", flash); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (matrix_out !== '0) begin errors++; $display("FAIL reset_matrix got=%h exp=0", matrix_out); end
    end
    clr = 1'b0;
    matrix_in = rand200();
    for (int i = 0; i < 20; i++) begin
      advance();
      checks++; if (matrix_out !== m_matrix) begin errors++; $display("FAIL idle_load cyc=%0d got=%h exp=%h", cyc, matrix_out, m_matrix); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy cyc=%0d got=%b exp=0", cyc, busy); end
    end
  endtask

  task automatic test_single_row();
    logic seen;
    n_done = 0;
    seen = 1'b0;
    row_mask = 20'h80000;
    start = 1'b1;
    advance();
    start = 1'b0;
    row_mask = 20'($urandom());
    for (int i = 0; i < 400 && !seen; i++) begin
      checks++; if (flash !== exp_flash) begin errors++; $display("FAIL single_flash cyc=%0d got=%h exp=%h", cyc, flash, exp_flash); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL single_done cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
      if (done === 1'b1) seen = 1'b1; else advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL single_timeout got=no_done exp=done"); end
    for (int i = 0; i < 4; i++) begin
      advance();
      checks++; if (done !== exp_done || flash !== exp_flash) begin errors++; $display("FAIL single_after cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_zero_mask();
    n_done = 0;
    row_mask = '0;
    start = 1'b1;
    advance();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy cyc=%0d got=%b exp=0", cyc, busy); end
      checks++; if (flash !== '0) begin errors++; $display("FAIL zero_flash cyc=%0d got=%h exp=0", cyc, flash); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL zero_pulse cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
      advance();
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_ignored_start();
    logic seen;
    n_done = 0;
    seen = 1'b0;
    row_mask = 20'h00400 | 20'($urandom() & 32'h7FC00);
    start = 1'b1;
    advance();
    start = 1'b0;
    for (int i = 0; i < 15; i++) advance();
    row_mask = 20'h00001;
    start = 1'b1;
    advance();
    start = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      checks++; if (flash !== exp_flash) begin errors++; $display("FAIL ignored_flash cyc=%0d got=%h exp=%h", cyc, flash, exp_flash); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL ignored_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
      if (done === 1'b1) seen = 1'b1; else advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL ignored_timeout got=no_done exp=done"); end
    for (int i = 0; i < 40; i++) begin
      advance();
      checks++; if (flash !== '0) begin errors++; $display("FAIL ignored_tail cyc=%0d got=%h exp=0", cyc, flash); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ignored_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_matrix_freeze();
    logic seen;
    seen = 1'b0;
    matrix_in = rand200();
    for (int i = 0; i < 20; i++) advance();
    row_mask = 20'($urandom()) | 20'h1;
    start = 1'b1;
    advance();
    start = 1'b0;
    matrix_in = 200'h1;
    for (int i = 0; i < 400 && !seen; i++) begin
      checks++; if (matrix_out !== m_matrix) begin errors++; $display("FAIL freeze_matrix cyc=%0d got=%h exp=%h", cyc, matrix_out, m_matrix); end
      checks++; if (flash !== exp_flash) begin errors++; $display("FAIL freeze_flash cyc=%0d got=%h exp=%h", cyc, flash, exp_flash); end
      if (done === 1'b1) seen = 1'b1; else advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL freeze_timeout got=no_done exp=done"); end
    for (int i = 0; i < 25; i++) begin
      advance();
      checks++; if (matrix_out !== m_matrix) begin errors++; $display("FAIL freeze_reload cyc=%0d got=%h exp=%h", cyc, matrix_out, m_matrix); end
    end
    checks++; if (matrix_out !== 200'h1) begin errors++; $display("FAIL freeze_final got=%h exp=1", matrix_out); end
  endtask

  task automatic test_start_on_tick();
    logic seen;
    logic [199:0] fresh;
    seen = 1'b0;
    for (int i = 0; i < 30 && !m_tick; i++) advance();
    checks++; if (!m_tick) begin errors++; $display("FAIL coinc_find got=no_tick exp=tick"); end
    fresh = rand200();
    matrix_in = fresh;
    row_mask = 20'($urandom()) | 20'h100;
    start = 1'b1;
    advance();
    start = 1'b0;
    checks++; if (matrix_out === fresh) begin errors++; $display("FAIL coinc_load got=%h exp=not_loaded", matrix_out); end
    checks++; if (flash !== '0 || busy !== 1'b1) begin errors++; $display("FAIL coinc_flash got=%b exp=0", |flash); end
    for (int i = 0; i < 400 && !seen; i++) begin
      checks++; if (flash !== exp_flash) begin errors++; $display("FAIL coinc_seq cyc=%0d got=%h exp=%h", cyc, flash, exp_flash); end
      checks++; if (matrix_out !== m_matrix) begin errors++; $display("FAIL coinc_matrix cyc=%0d got=%h exp=%h", cyc, matrix_out, m_matrix); end
      if (done === 1'b1) seen = 1'b1; else advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL coinc_timeout got=no_done exp=done"); end
    for (int i = 0; i < 3; i++) advance();
  endtask

  task automatic test_clr_abort();
    logic seen;
    n_done = 0;
    seen = 1'b0;
    row_mask = 20'($urandom()) | 20'h8;
    start = 1'b1;
    advance();
    start = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (flash !== '0) seen = 1'b1; else advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort_wait got=no_flash exp=flash"); end
    #10;
    clr = 1'b1;
    #1;
    checks++; if (flash !== '0) begin errors++; $display("FAIL abort_flash got=%h exp=0", flash); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (matrix_out !== '0) begin errors++; $display("FAIL abort_matrix got=%h exp=0", matrix_out); end
    model_reset();
    advance();
    clr = 1'b0;
    row_mask = 20'h00003;
    start = 1'b1;
    advance();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart got=%b exp=1", busy); end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_done_count got=%0d exp=0", n_done); end
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      checks++; if (flash !== exp_flash) begin errors++; $display("FAIL abort_seq cyc=%0d got=%h exp=%h", cyc, flash, exp_flash); end
      if (done === 1'b1) seen = 1'b1; else advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort_timeout got=no_done exp=done"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        start = 1'b1;
        row_mask = ($urandom_range(0, 7) == 0) ? 20'h0 : 20'($urandom());
      end else begin
        start = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) matrix_in = rand200();
      advance();
      checks++; if (flash !== exp_flash) begin errors++; $display("FAIL rand_flash cyc=%0d got=%h exp=%h", cyc, flash, exp_flash); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
      checks++; if (matrix_out !== m_matrix) begin errors++; $display("FAIL rand_matrix cyc=%0d got=%h exp=%h", cyc, matrix_out, m_matrix); end
    end
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_row();
    test_zero_mask();
    test_ignored_start();
    test_matrix_freeze();
    test_start_on_tick();
    test_clr_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
